// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator, MSB first, with unsigned and two's-complement modes.
// Operands are latched on start and mirrored to LEDs; gt/eq/lt hold until the next start.
module serial_mag_comparator #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq,
   output logic             lt,
   output logic [WIDTH-1:0] LED_A,
   output logic [WIDTH-1:0] LED_B
);

   localparam int IW = $clog2(WIDTH);
   localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_signed;
   logic [IW-1:0]    r_idx;
   logic             r_gt;
   logic             r_eq;
   logic             r_lt;

   logic w_bit_a;
   logic w_bit_b;
   logic w_differ;
   logic w_sign_bit;
   logic w_last;

   assign w_bit_a    = r_a[r_idx];
   assign w_bit_b    = r_b[r_idx];
   assign w_differ   = w_bit_a ^ w_bit_b;
   assign w_sign_bit = r_signed && (r_idx == IDX_TOP);
   assign w_last     = (r_idx == '0);

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = SCAN;
         SCAN:    if (w_differ || w_last) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_signed <= 1'b0;
         r_idx    <= IDX_TOP;
         r_gt     <= 1'b0;
         r_eq     <= 1'b0;
         r_lt     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a      <= A;
                  r_b      <= B;
                  r_signed <= signed_mode;
                  r_idx    <= IDX_TOP;
                  r_gt     <= 1'b0;
                  r_eq     <= 1'b0;
                  r_lt     <= 1'b0;
               end
            end
            SCAN: begin
               if (w_differ) begin
                  // A set sign bit means negative, so the sense flips there.
                  if (w_sign_bit) begin
                     r_gt <= w_bit_b;
                     r_lt <= w_bit_a;
                  end else begin
                     r_gt <= w_bit_a;
                     r_lt <= w_bit_b;
                  end
               end else if (w_last) begin
                  r_eq <= 1'b1;
               end else begin
                  r_idx <= r_idx - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy  = (r_state != IDLE);
   assign done  = (r_state == DONE);
   assign gt    = r_gt;
   assign eq    = r_eq;
   assign lt    = r_lt;
   assign LED_A = r_a;
   assign LED_B = r_b;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench for serial_mag_comparator: 4-bit and 8-bit instances, sampled 1 time unit after each rising edge.
module tb_serial_mag_comparator;

   logic       clk;
   logic       rst;
   logic       start;
   logic       signed_mode;
   logic [3:0] A;
   logic [3:0] B;
   logic       busy;
   logic       done;
   logic       gt;
   logic       eq;
   logic       lt;
   logic [3:0] LED_A;
   logic [3:0] LED_B;

   logic       start8;
   logic       signed8;
   logic [7:0] A8;
   logic [7:0] B8;
   logic       busy8;
   logic       done8;
   logic       gt8;
   logic       eq8;
   logic       lt8;
   logic [7:0] LED_A8;
   logic [7:0] LED_B8;

   int checks;
   int errors;

   serial_mag_comparator #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
      .A(A), .B(B), .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt),
      .LED_A(LED_A), .LED_B(LED_B)
   );

   serial_mag_comparator #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .signed_mode(signed8),
      .A(A8), .B(B8), .busy(busy8), .done(done8), .gt(gt8), .eq(eq8), .lt(lt8),
      .LED_A(LED_A8), .LED_B(LED_B8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present operands with start high, then step past accept edge k; start drops afterwards.
   task automatic accept4(input logic [3:0] a, input logic [3:0] b, input logic s);
      @(negedge clk);
      A = a; B = b; signed_mode = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic step;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; signed_mode = 1'b0; A = '0; B = '0;
      start8 = 1'b0; signed8 = 1'b0; A8 = '0; B8 = '0;
      step; step;
      checks++;
      if ({busy, done, gt, eq, lt} !== 5'b00000) begin
         errors++; $display("FAIL reset_flags got %b want 00000", {busy, done, gt, eq, lt});
      end
      checks++;
      if ({LED_A, LED_B} !== 8'h00) begin
         errors++; $display("FAIL reset_leds got %h want 00", {LED_A, LED_B});
      end
      checks++;
      if ({busy8, done8, gt8, eq8, lt8, LED_A8, LED_B8} !== 21'd0) begin
         errors++; $display("FAIL reset_dut8 got %h want 0", {busy8, done8, gt8, eq8, lt8, LED_A8, LED_B8});
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_unsigned_gt;
      accept4(4'd9, 4'd3, 1'b0);
      checks++;
      if ({busy, done, gt, eq, lt} !== 5'b10000) begin
         errors++; $display("FAIL gt_scan got %b want 10000", {busy, done, gt, eq, lt});
      end
      step;
      checks++;
      if ({busy, done, gt, eq, lt} !== 5'b11100) begin
         errors++; $display("FAIL gt_done got %b want 11100", {busy, done, gt, eq, lt});
      end
      checks++;
      if ({LED_A, LED_B} !== 8'h93) begin
         errors++; $display("FAIL gt_leds got %h want 93", {LED_A, LED_B});
      end
      step;
      checks++;
      if ({busy, done, gt, eq, lt} !== 5'b00100) begin
         errors++; $display("FAIL gt_hold got %b want 00100", {busy, done, gt, eq, lt});
      end
   endtask

   task automatic test_equal;
      accept4(4'd5, 4'd5, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         step;
         checks++;
         if ({busy, done, gt, eq, lt} !== 5'b10000) begin
            errors++; $display("FAIL eq_scan%0d got %b want 10000", i, {busy, done, gt, eq, lt});
         end
      end
      step;
      checks++;
      if ({busy, done, gt, eq, lt} !== 5'b11010) begin
         errors++; $display("FAIL eq_done got %b want 11010", {busy, done, gt, eq, lt});
      end
      step;
      checks++;
      if ({busy, done, gt, eq, lt} !== 5'b00010) begin
         errors++; $display("FAIL eq_idle got %b want 00010", {busy, done, gt, eq, lt});
      end
   endtask

   task automatic test_signed;
      accept4(4'b1000, 4'b0111, 1'b1);
      step;
      checks++;
      if ({done, gt, eq, lt} !== 4'b1001) begin
         errors++; $display("FAIL signed4 got %b want 1001", {done, gt, eq, lt});
      end
      step;
      accept4(4'b1000, 4'b0111, 1'b0);
      step;
      checks++;
      if ({done, gt, eq, lt} !== 4'b1100) begin
         errors++; $display("FAIL unsigned4 got %b want 1100", {done, gt, eq, lt});
      end
      step;
      for (int m = 0; m < 2; m++) begin
         @(negedge clk);
         A8 = 8'h80; B8 = 8'h7F; signed8 = (m == 0); start8 = 1'b1;
         step;
         start8 = 1'b0;
         step;
         checks++;
         if ({done8, gt8, eq8, lt8} !== ((m == 0) ? 4'b1001 : 4'b1100)) begin
            errors++; $display("FAIL w8_mode%0d got %b want %b", m, {done8, gt8, eq8, lt8},
                               ((m == 0) ? 4'b1001 : 4'b1100));
         end
         checks++;
         if ({LED_A8, LED_B8} !== 16'h807F) begin
            errors++; $display("FAIL w8_leds%0d got %h want 807f", m, {LED_A8, LED_B8});
         end
         step;
      end
   endtask

   task automatic test_ignore_start;
      accept4(4'd6, 4'd7, 1'b0);
      step;
      @(negedge clk);
      A = 4'd15; B = 4'd0; start = 1'b1;
      step;
      start = 1'b0;
      checks++;
      if ({busy, done, gt, eq, lt} !== 5'b10000) begin
         errors++; $display("FAIL ign_scan got %b want 10000", {busy, done, gt, eq, lt});
      end
      step;
      step;
      checks++;
      if ({busy, done, gt, eq, lt} !== 5'b11001) begin
         errors++; $display("FAIL ign_done got %b want 11001", {busy, done, gt, eq, lt});
      end
      checks++;
      if ({LED_A, LED_B} !== 8'h67) begin
         errors++; $display("FAIL ign_leds got %h want 67", {LED_A, LED_B});
      end
      step;
   endtask

   task automatic test_reset_in_scan;
      accept4(4'd3, 4'd3, 1'b0);
      step;
      @(negedge clk); rst = 1'b1;
      step;
      checks++;
      if ({busy, done, gt, eq, lt, LED_A, LED_B} !== 13'd0) begin
         errors++; $display("FAIL rst_scan got %h want 0", {busy, done, gt, eq, lt, LED_A, LED_B});
      end
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step;
         checks++;
         if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL rst_nodone%0d got %b want 00", i, {busy, done});
         end
      end
      accept4(4'd12, 4'd10, 1'b0);
      step;
      checks++;
      if ({busy, done, gt, eq, lt} !== 5'b10000) begin
         errors++; $display("FAIL rst_new_scan got %b want 10000", {busy, done, gt, eq, lt});
      end
      step;
      checks++;
      if ({busy, done, gt, eq, lt} !== 5'b11100) begin
         errors++; $display("FAIL rst_new_done got %b want 11100", {busy, done, gt, eq, lt});
      end
      step;
   endtask

   // 2 vs 1 resolves on bit 1 (n=3); DONE then one IDLE cycle before re-accept gives a period of 5.
   task automatic test_back_to_back;
      logic [4:0] exp;
      @(negedge clk);
      A = 4'd2; B = 4'd1; signed_mode = 1'b0; start = 1'b1;
      step;
      for (int t = 0; t < 15; t++) begin
         case (t % 5)
            3:       exp = 5'b11100;
            4:       exp = 5'b00100;
            default: exp = 5'b10000;
         endcase
         checks++;
         if ({busy, done, gt, eq, lt} !== exp) begin
            errors++; $display("FAIL b2b_t%0d got %b want %b", t, {busy, done, gt, eq, lt}, exp);
         end
         step;
      end
      @(negedge clk); start = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset;
      test_unsigned_gt;
      test_equal;
      test_signed;
      test_ignore_start;
      test_reset_in_scan;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
